fiber_dram_responder: RTL and testbench

- DRAM-side endpoint of the fiber bank's DRAM crossbar.
- Accepts line-fill read requests (address + valid/ready) and returns data on the bank's DRAM inbox channel (data/valid/ready) after a fixed latency.
- Accepts writebacks from the bank's DRAM outbox channel into a small backing store.
- Serves as the bank's DRAM model in simulation and as the per-bank DRAM port stub in integration.

---
 rtl/fiber_dram_responder.sv | 143 ++++++++++++++
 tb/tb_fiber_dram_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fiber_dram_responder.sv
// DRAM-side endpoint for a fiber bank: fixed-latency in-order line-fill reads from a
// small backing store, plus single-cycle writebacks with per-word valid tracking.
module fiber_dram_responder #(
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           ADDR_WIDTH   = 64,
  parameter int unsigned           MEM_WORDS    = 256,
  parameter int unsigned           READ_LATENCY = 4,
  parameter int unsigned           QUEUE_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = '0
) (
  input  logic                  i_clk,
  input  logic                  i_nreset,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic [DATA_WIDTH-1:0] o_dram_data,
  output logic                  o_dram_data_valid,
  input  logic                  i_dram_data_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic                  o_busy
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned LatW = $clog2(READ_LATENCY);
  // One cycle goes to the IDLE pop and one to the final sample, hence the -2.
  localparam logic [LatW-1:0] LatLoad = LatW'(READ_LATENCY - 2);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [IdxW-1:0]       cur_idx_q, cur_idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  wr_ready_q;
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [MEM_WORDS-1:0]  written_q, written_d;
  logic [IdxW-1:0]       fifo_mem [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] store [MEM_WORDS];

  logic            push, pop, wr_fire;
  logic [IdxW-1:0] rd_idx, wr_idx;
  logic            unused_addr;

  assign rd_idx      = i_rd_addr[IdxW-1:0];
  assign wr_idx      = i_wr_addr[IdxW-1:0];
  assign unused_addr = ^{i_rd_addr[ADDR_WIDTH-1:IdxW], i_wr_addr[ADDR_WIDTH-1:IdxW]};

  assign push    = i_rd_valid & rd_ready_q;
  assign pop     = (state_q == StIdle) & (count_q != '0);
  assign wr_fire = i_wr_valid & wr_ready_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    written_d  = written_q;
    if (push) wptr_d = (wptr_q == PtrW'(QUEUE_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PtrW'(QUEUE_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    if (wr_fire) written_d[wr_idx] = 1'b1;
    rd_ready_d = (count_d != CntW'(QUEUE_DEPTH));
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    cur_idx_d = cur_idx_q;
    data_d    = data_q;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          cur_idx_d = fifo_mem[rptr_q];
          lat_d     = LatLoad;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          // A same-cycle writeback to this word wins over the stored copy.
          if (wr_fire && (wr_idx == cur_idx_q)) begin
            data_d = i_wr_data;
          end else if (written_q[cur_idx_q]) begin
            data_d = store[cur_idx_q];
          end else begin
            data_d = FILL_PATTERN;
          end
          state_d = StResp;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StResp: begin
        if (i_dram_data_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      cur_idx_q  <= '0;
      data_q     <= '0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      written_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      cur_idx_q  <= cur_idx_d;
      data_q     <= data_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= 1'b1;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      written_q  <= written_d;
    end
  end

  // Storage is left unreset; written_q masks stale contents.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wptr_q] <= rd_idx;
    if (wr_fire) store[wr_idx] <= i_wr_data;
  end

  assign o_rd_ready        = rd_ready_q;
  assign o_wr_ready        = wr_ready_q;
  assign o_dram_data       = data_q;
  assign o_dram_data_valid = (state_q == StResp);
  assign o_busy            = (count_q != '0) | (state_q != StIdle);

endmodule

// File: tb/tb_fiber_dram_responder.sv
// Directed bench for fiber_dram_responder: stimulus pushes expected responses into a
// scoreboard queue; a negedge monitor pops and compares on every response handshake.
module tb_fiber_dram_responder;
  localparam int unsigned Lat = 4;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic [63:0] rd_addr = '0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [15:0] dram_data;
  logic        dram_valid;
  logic        dram_ready = 1'b1;
  logic [63:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        busy;

  fiber_dram_responder #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (64),
    .MEM_WORDS   (256),
    .READ_LATENCY(Lat),
    .QUEUE_DEPTH (4),
    .FILL_PATTERN(16'h0000)
  ) dut (
    .i_clk            (clk),
    .i_nreset         (nreset),
    .i_rd_addr        (rd_addr),
    .i_rd_valid       (rd_valid),
    .o_rd_ready       (rd_ready),
    .o_dram_data      (dram_data),
    .o_dram_data_valid(dram_valid),
    .i_dram_data_ready(dram_ready),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .i_wr_valid       (wr_valid),
    .o_wr_ready       (wr_ready),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;
  int unsigned last_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (nreset && dram_valid && dram_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got %0h want none", dram_data);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", dram_data, mon_e.data);
        check("resp_latency", (cyc - mon_e.acc) >= Lat, 1);
      end
    end
  end

  task automatic do_read(input logic [63:0] a, input logic [15:0] e, input bit track);
    bit acc = 0;
    bit r;
    rd_addr  = a;
    rd_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      r = rd_ready;
      @(posedge clk);
      #1;
      if (r) acc = 1;
    end
    rd_valid = 1'b0;
    check("rd_accept", acc, 1);
    last_acc = cyc;
    if (acc && track) sb.push_back('{data: e, acc: cyc});
  endtask

  task automatic do_write(input logic [63:0] a, input logic [15:0] d);
    bit acc = 0;
    bit r;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      r = wr_ready;
      @(posedge clk);
      #1;
      if (r) acc = 1;
    end
    wr_valid = 1'b0;
    check("wr_accept", acc, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !busy && !dram_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain", (sb.size() == 0) && !busy, 1);
  endtask

  int unsigned t0, first_acc;
  int          hs_before;

  initial begin
    // Reset values
    #1 nreset = 1'b0;
    #1;
    check("rst_valid", dram_valid, 0);
    check("rst_data", dram_data, 16'h0000);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    check("rel_rd_ready_low", rd_ready, 0);
    @(posedge clk);
    #1;
    check("rel_rd_ready", rd_ready, 1);
    check("rel_wr_ready", wr_ready, 1);

    // 1: latency and single-cycle pulse
    do_read(64'h0000_0000_FFFF_FFFF, 16'h0000, 1);
    t0 = last_acc;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("t1_valid_timing", dram_valid, (k == Lat) ? 1 : 0);
    end
    drain();

    // 2: write then aliased reads
    do_write(64'h10, 16'hBEEF);
    do_read(64'h10, 16'hBEEF, 1);
    do_read(64'h110, 16'hBEEF, 1);
    drain();

    // 3: backpressure holds the response
    dram_ready = 1'b0;
    do_read(64'h10, 16'hBEEF, 1);
    for (int i = 0; i < 50 && !dram_valid; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("t3_hold_valid", dram_valid, 1);
      check("t3_hold_data", dram_data, 16'hBEEF);
    end
    @(posedge clk);
    #1 dram_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valid_drop", dram_valid, 0);
    drain();

    // 4: fill the FIFO, then release in order
    for (int i = 1; i <= 6; i++) do_write(64'(i), 16'hA000 + 16'(i));
    dram_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      do_read(64'(i), 16'hA000 + 16'(i), 1);
      if (i == 1) first_acc = last_acc;
    end
    check("t4_back_to_back", last_acc - first_acc, 4);
    check("t4_rd_ready_full", rd_ready, 0);
    check("t4_busy", busy, 1);
    hs_before = hs_cnt;
    fork
      do_read(64'h6, 16'hA006, 1);
      begin
        repeat (3) @(posedge clk);
        #1 dram_ready = 1'b1;
      end
    join
    check("t4_6th_after_resp", hs_cnt > hs_before, 1);
    drain();

    // 5: writeback forwarded into the sampling read
    do_read(64'h20, 16'h1234, 1);
    repeat (3) @(posedge clk);
    #1;
    do_write(64'h20, 16'h1234);
    drain();

    // 6: reset during WAIT discards data and written bits
    do_write(64'h30, 16'h5555);
    do_read(64'h30, 16'h5555, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_busy_pre", busy, 1);
    nreset = 1'b0;
    #1;
    check("t6_valid_drop", dram_valid, 0);
    check("t6_rd_ready_drop", rd_ready, 0);
    check("t6_wr_ready_drop", wr_ready, 0);
    check("t6_busy_drop", busy, 0);
    #10 nreset = 1'b1;
    do_read(64'h30, 16'h0000, 1);
    drain();
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
